// File: rtl/opb_register_simulink2ppc.sv
// OPB slave exposing a fabric-to-processor hold register and an update counter.
// DATA word returns the last captured user value; COUNT word returns the number of captures.
module opb_register_simulink2ppc #(
    parameter logic [31:0] C_BASEADDR   = 32'h0000_0000,
    parameter logic [31:0] C_HIGHADDR   = 32'h0000_00FF,
    parameter int unsigned C_OPB_AWIDTH = 32,
    parameter int unsigned C_OPB_DWIDTH = 32,
    parameter              C_FAMILY     = "virtex6"
) (
    input  logic                        OPB_Clk,
    input  logic                        OPB_Rst,
    input  logic [0:C_OPB_AWIDTH-1]     OPB_ABus,
    input  logic [0:C_OPB_DWIDTH/8-1]   OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1]     OPB_DBus,
    input  logic                        OPB_RNW,
    input  logic                        OPB_select,
    input  logic                        OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1]     Sl_DBus,
    output logic                        Sl_errAck,
    output logic                        Sl_retry,
    output logic                        Sl_toutSup,
    output logic                        Sl_xferAck,
    input  logic [31:0]                 user_data_in,
    input  logic                        user_data_valid
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned AW     = C_OPB_AWIDTH;
    localparam logic [AW-1:0] BASE_A = AW'(C_BASEADDR);
    localparam logic [AW-1:0] SPAN_A = AW'(C_HIGHADDR - C_BASEADDR);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACK     = 2'd1,
        S_HOLDOFF = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                ack_q, ack_d;
    logic [DATA_W-1:0]   dbus_q, dbus_d;
    logic [DATA_W-1:0]   hold_q, hold_d;
    logic [DATA_W-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]       rel_addr;
    logic                hit_c;
    logic                is_cnt_c;
    logic                clr_c;
    logic                unused_ok;

    // Window test as an offset from the base so an all-zero base needs no lower-bound compare.
    assign rel_addr = OPB_ABus - BASE_A;
    assign hit_c    = OPB_select && (rel_addr <= SPAN_A);
    assign is_cnt_c = OPB_ABus[AW-3];

    assign unused_ok = ^{OPB_seqAddr, OPB_DBus, C_FAMILY};

    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            state_q <= S_IDLE;
            ack_q   <= 1'b0;
            dbus_q  <= '0;
            hold_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            dbus_q  <= dbus_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
        end
    end

    // Transfer sequencing: one ack, then a hold-off cycle before the next request is seen.
    always_comb begin
        state_d = state_q;
        ack_d   = 1'b0;
        dbus_d  = '0;
        clr_c   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (hit_c) begin
                    state_d = S_ACK;
                    ack_d   = 1'b1;
                    if (OPB_RNW) begin
                        dbus_d = is_cnt_c ? cnt_q : hold_q;
                    end else begin
                        clr_c = is_cnt_c && (|OPB_BE);
                    end
                end
            end
            S_ACK:     state_d = S_HOLDOFF;
            S_HOLDOFF: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // A clear coinciding with a capture still counts that capture.
    always_comb begin
        hold_d = user_data_valid ? user_data_in : hold_q;
        cnt_d  = (clr_c ? {DATA_W{1'b0}} : cnt_q) + DATA_W'(user_data_valid);
    end

    assign Sl_xferAck = ack_q;
    assign Sl_DBus    = C_OPB_DWIDTH'(dbus_q);
    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;

endmodule

// File: doc/opb_register_simulink2ppc.md
OPB_REGISTER_SIMULINK2PPC -- requirements
Module: opb_register_simulink2ppc

Interface
REQ-001 SHALL have parameter C_BASEADDR, default 32'h00000000, first byte address of the slave window.
REQ-002 SHALL have parameter C_HIGHADDR, default 32'h000000FF, last byte address of the slave window.
REQ-003 SHALL have parameter C_OPB_AWIDTH, default 32, OPB address width.
REQ-004 SHALL have parameter C_OPB_DWIDTH, default 32, OPB data width.
REQ-005 SHALL have parameter C_FAMILY, default "virtex6", target family (informational).
REQ-006 SHALL have port OPB_Clk  input  1  sole clock for the bus side and the user side.
REQ-007 SHALL have port OPB_Rst  input  1  reset, asynchronous, active-high.
REQ-008 SHALL have port OPB_ABus  input  [0:31]  bus address, bit 31 = LSB.
REQ-009 SHALL have port OPB_BE  input  [0:3]  byte enables.
REQ-010 SHALL have port OPB_DBus  input  [0:31]  write data.
REQ-011 SHALL have port OPB_RNW  input  1  1 = read, 0 = write.
REQ-012 SHALL have port OPB_select  input  1  master transfer qualifier.
REQ-013 SHALL have port OPB_seqAddr  input  1  sequential-address hint, ignored.
REQ-014 SHALL have port Sl_DBus  output  [0:31]  read data; all zero unless Sl_xferAck=1.
REQ-015 SHALL have ports Sl_errAck, Sl_retry, Sl_toutSup  output  1 each  tied to 0.
REQ-016 SHALL have port Sl_xferAck  output  1  transfer acknowledge.
REQ-017 SHALL have port user_data_in  input  [31:0]  value from fabric logic.
REQ-018 SHALL have port user_data_valid  input  1  capture strobe for user_data_in.

Function
REQ-019 SHALL decode hit = OPB_select AND C_BASEADDR <= OPB_ABus <= C_HIGHADDR; offset = OPB_ABus[29] (0 -> DATA word, 1 -> COUNT word).
REQ-020 SHALL load a 32-bit hold register from user_data_in on every cycle with user_data_valid=1.
REQ-021 SHALL increment a 32-bit update counter on each user_data_valid=1, wrapping 0xFFFFFFFF -> 0x00000000.
REQ-022 SHALL implement FSM IDLE -> ACK -> HOLDOFF -> IDLE; IDLE->ACK on hit; ACK->HOLDOFF and HOLDOFF->IDLE unconditionally.
REQ-023 SHALL assert Sl_xferAck for exactly one cycle, the cycle after hit is sampled in IDLE (latency 1).
REQ-024 SHALL ignore OPB_select during ACK and HOLDOFF; no back-to-back acks, minimum 3 cycles between acks.
REQ-025 SHALL, on a read, drive Sl_DBus during the ack cycle with the hold register (DATA) or counter (COUNT), as sampled at the IDLE->ACK edge, Sl_DBus[0] = bit 31.
REQ-026 SHALL, when user_data_valid and the IDLE->ACK edge coincide, return the pre-update value (old hold / old count).
REQ-027 SHALL acknowledge writes to DATA with no state change.
REQ-028 SHALL, on a write to COUNT with any OPB_BE bit set, clear the counter at the IDLE->ACK edge; a write with OPB_BE=0000 is acked with no effect.
REQ-029 SHALL, when a counter clear and user_data_valid coincide, leave the counter at 0x00000001.
REQ-030 SHALL never respond (no ack, Sl_DBus=0) when hit=0 or when the address is outside the window.

Reset
REQ-031 SHALL, when OPB_Rst=1, immediately force FSM=IDLE, Sl_xferAck=0, Sl_DBus=0, hold register=0, and counter=0, including mid-transfer.
REQ-032 SHALL ignore user_data_valid and bus requests while OPB_Rst=1 and resume on the first clock edge after deassertion.

Verification
REQ-033 SHALL verify: user_data_valid with 0xDEADBEEF, then read BASE+0 -> one-cycle Sl_xferAck one cycle after select, Sl_DBus=0xDEADBEEF, Sl_DBus=0 before and after the ack.
REQ-034 SHALL verify: 5 valid strobes, read BASE+4 -> 0x00000005; write BASE+4 with BE=1111, then read -> 0x00000000; write with BE=0000 leaves the count unchanged.
REQ-035 SHALL verify: hold=0x11111111, valid with 0x22222222 in the same cycle as the hit on BASE+0 -> read 0x11111111; next read -> 0x22222222.
REQ-036 SHALL verify: counter preset to 0xFFFFFFFF by strobes, one more valid -> reads 0x00000000; clear coincident with valid -> reads 0x00000001.
REQ-037 SHALL verify: select held high for 6 cycles on a hit -> acks at cycles 1 and 4 only; address C_HIGHADDR+4 -> no ack over 10 cycles.
REQ-038 SHALL verify: OPB_Rst asserted during the ACK cycle -> Sl_xferAck and Sl_DBus drop to 0 without a clock edge, and DATA/COUNT read 0 after release.
